mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 20 ++
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder_ram_sync.sv | 27 ++
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared encodings for the mem_responder slice: command codes, FSM states and I/O addresses.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        MNONE    = 2'b00,
        MREAD    = 2'b01,
        MWRITE   = 2'b10,
        MILLEGAL = 2'b11
    } mem_cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD1  = 2'b01,
        RD2  = 2'b10
    } state_e;

    localparam logic [8:0] IO_LEDR_ADDR = 9'h100;
    localparam logic [8:0] IO_SW_ADDR   = 9'h140;

endpackage

// File: rtl/mem_responder_if.sv
// Controller-to-responder memory bus, grouped so master and slave views are explicit.
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    // No valid/ready pair: mem_cmd is sampled on every rising edge; read_data follows an MREAD by
    // one edge, and rd_valid rises only once the same address has been held for a second MREAD.
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              rd_valid;
    logic              proto_err;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, rd_valid, proto_err
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, rd_valid, proto_err
    );
endinterface

// File: rtl/mem_responder_ram_sync.sv
// Single-port RAM with synchronous write and registered synchronous read; contents have no reset.
module ram_sync #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Memory responder: RAM below 0x100, optional switch/LED I/O (MEM_RESPONDER_IO_EN), read-hold FSM.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 9,
    parameter int RAM_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_responder_if.slave        bus,
    input  logic [7:0]            sw,
    output logic [7:0]            LEDR,
    output state_e                dbg_state_o
);
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    mem_cmd_e          cmd;
    logic              is_ram;
    logic              is_sw_rd;
    logic              is_led_wr;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_valid_q;
    logic              proto_err_q;
    logic              from_ram_q;
    logic [DATA_W-1:0] reg_data_q;

    assign cmd    = mem_cmd_e'(bus.mem_cmd);
    assign is_ram = ~bus.mem_addr[8];

`ifdef MEM_RESPONDER_IO_EN
    logic [7:0] ledr_q;

    assign is_sw_rd  = (bus.mem_addr == ADDR_W'(IO_SW_ADDR));
    assign is_led_wr = (bus.mem_addr == ADDR_W'(IO_LEDR_ADDR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ledr_q <= '0;
        end else if (cmd == MWRITE && is_led_wr) begin
            ledr_q <= bus.write_data[7:0];
        end
    end

    assign LEDR = ledr_q;
`else
    logic unused_io;

    assign is_sw_rd  = 1'b0;
    assign is_led_wr = 1'b0;
    assign unused_io = ^{sw, is_led_wr};
    assign LEDR      = '0;
`endif

    // Gating with reset keeps an access that coincides with reset from touching the RAM.
    assign ram_we = ~reset && (cmd == MWRITE) && is_ram;
    assign ram_re = ~reset && (cmd == MREAD) && is_ram;

    ram_sync #(
        .DEPTH (RAM_DEPTH),
        .WIDTH (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (bus.mem_addr[RAM_AW-1:0]),
        .wdata_i (bus.write_data),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rd_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
            from_ram_q  <= 1'b0;
            reg_data_q  <= '0;
        end else begin
            case (cmd)
                MREAD: begin
                    from_ram_q <= is_ram;
                    reg_data_q <= is_sw_rd ? DATA_W'(sw) : '0;
                    addr_q     <= bus.mem_addr;
                    if (state_q != IDLE && bus.mem_addr != addr_q) begin
                        // Address moved under a held read: flag it and start counting again.
                        proto_err_q <= 1'b1;
                        state_q     <= RD1;
                        rd_valid_q  <= 1'b0;
                    end else if (state_q == IDLE) begin
                        state_q    <= RD1;
                        rd_valid_q <= 1'b0;
                    end else begin
                        state_q    <= RD2;
                        rd_valid_q <= 1'b1;
                    end
                end
                MILLEGAL: begin
                    proto_err_q <= 1'b1;
                    state_q     <= IDLE;
                    rd_valid_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    rd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM data is already registered inside ram_sync; non-RAM reads land in reg_data_q.
    assign bus.read_data = from_ram_q ? ram_rdata : reg_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.proto_err = proto_err_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, multi-cycle corner sequences, random vs model.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int DW = 16;
    localparam int AW = 9;
`ifdef MEM_RESPONDER_IO_EN
    localparam bit IO_ON = 1'b1;
`else
    localparam bit IO_ON = 1'b0;
`endif

    // clock / reset
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic [7:0] ledr;
    state_e     dbg_state;

    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_responder #(.DATA_W(DW), .ADDR_W(AW), .RAM_DEPTH(256)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .sw          (sw),
        .LEDR        (ledr),
        .dbg_state_o (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // reference model: a read "run" counts consecutive MREADs of one address
    logic [15:0] ram_m   [256];
    bit          known_m [256];
    int          run_m;
    logic [8:0]  last_m;
    logic [15:0] rd_m;
    bit          rd_known_m;
    bit          err_m;
    logic [7:0]  led_m;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic state_e run_state(input int run);
        if (run == 0) return IDLE;
        if (run == 1) return RD1;
        return RD2;
    endfunction

    function automatic logic [15:0] peek(input logic [8:0] a, input logic [7:0] s);
        if (!a[8]) return ram_m[a[7:0]];
        if (IO_ON && a == 9'h140) return {8'h00, s};
        return 16'h0000;
    endfunction

    task automatic model_reset();
        run_m = 0; rd_m = 16'h0; rd_known_m = 1'b1; err_m = 1'b0; led_m = 8'h0;
    endtask

    task automatic model_edge(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] wd);
        case (cmd)
            2'b01: begin
                if (run_m > 0 && a != last_m) begin
                    err_m = 1'b1;
                    run_m = 1;
                end else begin
                    run_m = (run_m >= 2) ? 2 : run_m + 1;
                end
                last_m     = a;
                rd_m       = peek(a, sw);
                rd_known_m = a[8] ? 1'b1 : known_m[a[7:0]];
            end
            2'b10: begin
                run_m = 0;
                if (!a[8]) begin
                    ram_m[a[7:0]]   = wd;
                    known_m[a[7:0]] = 1'b1;
                end else if (IO_ON && a == 9'h100) begin
                    led_m = wd[7:0];
                end
            end
            2'b11: begin
                run_m = 0;
                err_m = 1'b1;
            end
            default: run_m = 0;
        endcase
    endtask

    // driver tasks
    task automatic step(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] wd);
        bus.mem_cmd    = cmd;
        bus.mem_addr   = a;
        bus.write_data = wd;
        @(posedge clk);
        model_edge(cmd, a, wd);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, " rst read_data"}, 32'(bus.read_data), 32'h0);
        check({tag, " rst rd_valid"},  32'(bus.rd_valid), 32'h0);
        check({tag, " rst proto_err"}, 32'(bus.proto_err), 32'h0);
        check({tag, " rst LEDR"},      32'(ledr), 32'h0);
        check({tag, " rst state"},     32'(dbg_state), 32'(IDLE));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_model(input string tag);
        if (rd_known_m) check({tag, " read_data"}, 32'(bus.read_data), 32'(rd_m));
        check({tag, " rd_valid"},  32'(bus.rd_valid), 32'(run_m == 2));
        check({tag, " proto_err"}, 32'(bus.proto_err), 32'(err_m));
        check({tag, " LEDR"},      32'(ledr), 32'(led_m));
        check({tag, " state"},     32'(dbg_state), 32'(run_state(run_m)));
    endtask

    typedef struct {
        bit          pre_rst;
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        bit          exp_v;
        bit          exp_err;
        state_e      exp_st;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [8:0]  pool [8];
        logic [8:0]  a;
        logic [1:0]  c;
        int          r;

        reset = 1'b0; sw = 8'h00;
        bus.mem_cmd = 2'b00; bus.mem_addr = '0; bus.write_data = '0;
        for (int i = 0; i < 256; i++) begin
            known_m[i] = 1'b0;
            ram_m[i]   = 16'h0;
        end
        last_m = '0;
        model_reset();
        #2;
        do_reset("init");

        tbl[0]  = '{0, MWRITE, 9'h005, 16'hBEEF, 16'h0000, 0, 0, IDLE};
        tbl[1]  = '{0, MREAD,  9'h005, 16'h0000, 16'hBEEF, 0, 0, RD1};
        tbl[2]  = '{0, MREAD,  9'h005, 16'h0000, 16'hBEEF, 1, 0, RD2};
        tbl[3]  = '{0, MREAD,  9'h005, 16'h0000, 16'hBEEF, 1, 0, RD2};
        tbl[4]  = '{0, MNONE,  9'h000, 16'h0000, 16'hBEEF, 0, 0, IDLE};
        tbl[5]  = '{0, MWRITE, 9'h006, 16'h1234, 16'hBEEF, 0, 0, IDLE};
        tbl[6]  = '{0, MWRITE, 9'h010, 16'h7777, 16'hBEEF, 0, 0, IDLE};
        tbl[7]  = '{0, MREAD,  9'h1FF, 16'h0000, 16'h0000, 0, 0, RD1};
        tbl[8]  = '{0, MREAD,  9'h1FF, 16'h0000, 16'h0000, 1, 0, RD2};
        tbl[9]  = '{0, MWRITE, 9'h1FF, 16'h5555, 16'h0000, 0, 0, IDLE};
        tbl[10] = '{0, MREAD,  9'h005, 16'h0000, 16'hBEEF, 0, 0, RD1};
        tbl[11] = '{0, MREAD,  9'h006, 16'h0000, 16'h1234, 0, 1, RD1};
        tbl[12] = '{0, MREAD,  9'h006, 16'h0000, 16'h1234, 1, 1, RD2};
        tbl[13] = '{1, 2'b11,  9'h010, 16'hDEAD, 16'h0000, 0, 1, IDLE};
        tbl[14] = '{0, MREAD,  9'h010, 16'h0000, 16'h7777, 0, 1, RD1};
        tbl[15] = '{0, MREAD,  9'h006, 16'h0000, 16'h1234, 0, 1, RD1};

        foreach (tbl[i]) begin
            if (tbl[i].pre_rst) do_reset($sformatf("vec%0d", i));
            step(tbl[i].cmd, tbl[i].addr, tbl[i].wd);
            check($sformatf("vec%0d read_data", i), 32'(bus.read_data), 32'(tbl[i].exp_rd));
            check($sformatf("vec%0d rd_valid", i),  32'(bus.rd_valid), 32'(tbl[i].exp_v));
            check($sformatf("vec%0d proto_err", i), 32'(bus.proto_err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d state", i),     32'(dbg_state), 32'(tbl[i].exp_st));
            check($sformatf("vec%0d LEDR", i),      32'(ledr), 32'h0);
        end

        // I/O window: switches read back, LED register written
        sw = 8'h5A;
        step(MREAD, 9'h140, 16'h0);
        step(MREAD, 9'h140, 16'h0);
        check("io sw read_data", 32'(bus.read_data), IO_ON ? 32'h005A : 32'h0);
        check("io sw rd_valid", 32'(bus.rd_valid), 32'h1);
        step(MWRITE, 9'h100, 16'h00C3);
        check("io ledr write", 32'(ledr), IO_ON ? 32'hC3 : 32'h0);
        step(MNONE, 9'h100, 16'hFFFF);
        check("io ledr hold", 32'(ledr), IO_ON ? 32'hC3 : 32'h0);
        check("io read_data hold", 32'(bus.read_data), IO_ON ? 32'h005A : 32'h0);

        // reset landing between edges while a read is held in RD2
        step(MREAD, 9'h005, 16'h0);
        step(MREAD, 9'h005, 16'h0);
        check("rd2 before reset rd_valid", 32'(bus.rd_valid), 32'h1);
        check("rd2 before reset read_data", 32'(bus.read_data), 32'hBEEF);
        do_reset("mid_rd2");
        step(MREAD, 9'h005, 16'h0);
        check("reread after reset", 32'(bus.read_data), 32'hBEEF);

        // write presented while reset spans the edge must not land
        @(negedge clk);
        bus.mem_cmd = MWRITE; bus.mem_addr = 9'h005; bus.write_data = 16'h0000;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(MNONE, 9'h005, 16'h0);
        step(MREAD, 9'h005, 16'h0);
        check("write during reset dropped", 32'(bus.read_data), 32'hBEEF);

        // randomized traffic against the model
        pool[0] = 9'h005; pool[1] = 9'h006; pool[2] = 9'h010; pool[3] = 9'h0FF;
        pool[4] = 9'h1FF; pool[5] = 9'h140; pool[6] = 9'h100; pool[7] = 9'h020;
        a = 9'h005;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 19);
            if (r < 9)       c = MREAD;
            else if (r < 15) c = MWRITE;
            else if (r < 19) c = MNONE;
            else             c = 2'b11;
            if ($urandom_range(0, 3) == 0) a = pool[$urandom_range(0, 7)];
            sw = 8'($urandom);
            step(c, a, 16'($urandom));
            check_model($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
